// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, bubble encoding and reset vector.
// Imported by the fetch, decode and hazard logic so they agree on these values.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Instructions are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold (stall) and bubble (flush) controls.
// Hold has priority; a bubble clears instruction and valid but keeps the PC fields.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP_INS  = NOP_WORD
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] pc_d,
  input  logic [31:0] ins_d,
  output logic [31:0] pc_q,
  output logic [31:0] pc4_q,
  output logic [31:0] ins_q,
  output logic        valid_q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, and the asynchronous reset lives in the sensitivity list.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else if (!hold) begin
      if (flush) begin
        ins_q   <= NOP_INS;
        valid_q <= 1'b0;
      end else begin
        pc_q    <= pc_d;
        pc4_q   <= pc_d + 32'd4;
        ins_q   <= ins_d;
        valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/RUN/HALT control, next-PC selection and the
// IF/ID register. Priority in RUN is stall > halt > redirect > sequential.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_VECTOR,
  parameter int          IM_AWIDTH = 10,
  parameter logic [31:0] NOP_INS   = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          target_i,
  input  logic                 halt_i,
  output logic [IM_AWIDTH-1:0] im_addr_o,
  input  logic [31:0]          im_data_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          ifid_pc_o,
  output logic [31:0]          ifid_pc4_o,
  output logic [31:0]          ifid_ins_o,
  output logic                 ifid_valid_o,
  output logic                 halted_o
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         ifid_hold, ifid_flush;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b1;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (stall_i) begin
          ifid_hold = 1'b1;
        end else if (halt_i) begin
          state_nxt = ST_HALT;
        end else if (redirect_i) begin
          pc_nxt = word_align(target_i);
        end else begin
          pc_nxt     = pc + 32'd4;
          ifid_flush = 1'b0;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      halted_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      halted_o <= (state_nxt == ST_HALT);
    end
  end

  assign pc_o      = pc;
  assign im_addr_o = pc[IM_AWIDTH+1:2];

  ifid_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INS  (NOP_INS)
  ) u_ifid_reg (
    .clk     (clk),
    .rstn    (rstn),
    .hold    (ifid_hold),
    .flush   (ifid_flush),
    .pc_d    (pc),
    .ins_d   (im_data_i),
    .pc_q    (ifid_pc_o),
    .pc4_q   (ifid_pc4_o),
    .ins_q   (ifid_ins_o),
    .valid_q (ifid_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// behavioural fetch model; a second instance covers PC wrap-around and ROM aliasing.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, stall, redirect, halt;
  logic [31:0] target;
  logic [9:0]  im_addr;
  logic [31:0] im_data, pc, ifid_pc, ifid_pc4, ifid_ins;
  logic        ifid_valid, halted;
  logic [31:0] rom [0:1023];
  assign im_data = rom[im_addr];

  if_stage dut (
    .clk(clk), .rstn(rstn), .stall_i(stall), .redirect_i(redirect), .target_i(target),
    .halt_i(halt), .im_addr_o(im_addr), .im_data_i(im_data), .pc_o(pc),
    .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4), .ifid_ins_o(ifid_ins),
    .ifid_valid_o(ifid_valid), .halted_o(halted)
  );

  logic        rstn_w;
  logic [3:0]  im_addr_w;
  logic [31:0] im_data_w, pc_w, ifid_pc_w, ifid_pc4_w, ifid_ins_w;
  logic        ifid_valid_w, halted_w;
  logic [31:0] rom_w [0:15];
  assign im_data_w = rom_w[im_addr_w];

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .IM_AWIDTH(4)) dut_w (
    .clk(clk), .rstn(rstn_w), .stall_i(1'b0), .redirect_i(1'b0), .target_i(32'h0),
    .halt_i(1'b0), .im_addr_o(im_addr_w), .im_data_i(im_data_w), .pc_o(pc_w),
    .ifid_pc_o(ifid_pc_w), .ifid_pc4_o(ifid_pc4_w), .ifid_ins_o(ifid_ins_w),
    .ifid_valid_o(ifid_valid_w), .halted_o(halted_w)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch unit, stepped once per rising edge.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_ins;
  bit          m_valid, m_boot, m_halt;

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_ins = NOP;
    m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; target = 32'h0;
  endtask

  // Apply the fetch rules to the model with the inputs now present, then clock.
  task automatic cycle();
    if (rstn) begin
      if (m_boot || m_halt) begin
        m_boot = 1'b0; m_ins = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        if (halt) begin
          m_halt = 1'b1; m_ins = NOP; m_valid = 1'b0;
        end else if (redirect) begin
          m_pc = target - (target % 4); m_ins = NOP; m_valid = 1'b0;
        end else begin
          m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_ins = rom[(m_pc / 4) % 1024];
          m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b1; rstn_w = 1'b1;
    #1 rstn = 1'b0; rstn_w = 1'b0;
    model_reset();
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp %h", ifid_pc, 32'h0); end
    checks++; if (ifid_pc4 !== 32'h4) begin errors++; $display("FAIL reset_ifid_pc4 got %h exp %h", ifid_pc4, 32'h4); end
    checks++; if (ifid_ins !== NOP) begin errors++; $display("FAIL reset_ins got %h exp %h", ifid_ins, NOP); end
    checks++; if (ifid_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ifid_valid, halted); end
    @(posedge clk); #1 rstn = 1'b1;
    cycle();
    checks++; if (ifid_valid !== 1'b0 || ifid_ins !== NOP) begin errors++; $display("FAIL boot_bubble got %b/%h exp 0/%h", ifid_valid, ifid_ins, NOP); end
    checks++; if (pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL boot_pc got %h/%b exp 0/0", pc, halted); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ifid_pc !== 32'(4 * i) || ifid_ins !== rom[i] || ifid_valid !== 1'b1 || ifid_pc4 !== 32'(4 * i + 4))
        begin errors++; $display("FAIL seq_%0d got pc %h pc4 %h ins %h v %b exp pc %h ins %h v 1", i, ifid_pc, ifid_pc4, ifid_ins, ifid_valid, 4 * i, rom[i]); end
    end
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'd12); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (pc !== 32'd12 || ifid_pc !== 32'd8 || ifid_ins !== rom[2] || ifid_valid !== 1'b1)
        begin errors++; $display("FAIL stall_%0d got pc %h ifid %h ins %h v %b exp pc c ifid 8 ins %h v 1", i, pc, ifid_pc, ifid_ins, ifid_valid, rom[2]); end
    end
    stall = 1'b0;
    cycle();
    checks++; if (ifid_pc !== 32'd12 || ifid_ins !== rom[3] || pc !== 32'd16)
      begin errors++; $display("FAIL stall_release got ifid %h ins %h pc %h exp c %h 10", ifid_pc, ifid_ins, pc, rom[3]); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; target = 32'h0000_0043;
    cycle();
    redirect = 1'b0;
    checks++; if (pc !== 32'h40 || im_addr !== 10'd16) begin errors++; $display("FAIL redir_pc got %h/%h exp 40/10", pc, im_addr); end
    checks++; if (ifid_valid !== 1'b0 || ifid_ins !== NOP || ifid_pc !== 32'd12)
      begin errors++; $display("FAIL redir_bubble got v %b ins %h pc %h exp 0 %h c", ifid_valid, ifid_ins, ifid_pc, NOP); end
    cycle();
    checks++; if (ifid_pc !== 32'h40 || ifid_pc4 !== 32'h44 || ifid_ins !== rom[16] || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL redir_target got pc %h pc4 %h ins %h v %b exp 40 44 %h 1", ifid_pc, ifid_pc4, ifid_ins, ifid_valid, rom[16]); end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] t;
    t = $urandom;
    stall = 1'b1; redirect = 1'b1; halt = 1'b1; target = t;
    cycle();
    checks++; if (pc !== 32'h44 || ifid_pc !== 32'h40 || ifid_valid !== 1'b1 || halted !== 1'b0)
      begin errors++; $display("FAIL stall_redir_hold got pc %h ifid %h v %b h %b exp 44 40 1 0", pc, ifid_pc, ifid_valid, halted); end
    stall = 1'b0; halt = 1'b0;
    cycle();
    redirect = 1'b0;
    checks++; if (pc !== {t[31:2], 2'b00} || ifid_valid !== 1'b0)
      begin errors++; $display("FAIL stall_redir_take got pc %h v %b exp %h 0", pc, ifid_valid, {t[31:2], 2'b00}); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; target = 32'hFC;
    cycle();
    redirect = 1'b0; halt = 1'b1;
    cycle();
    halt = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 32'hFC) begin errors++; $display("FAIL halt_enter got h %b pc %h exp 1 fc", halted, pc); end
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); redirect = 1'($urandom); halt = 1'($urandom); target = $urandom;
      cycle();
      checks++;
      if (halted !== 1'b1 || pc !== 32'hFC || ifid_valid !== 1'b0 || ifid_ins !== NOP)
        begin errors++; $display("FAIL halt_hold_%0d got h %b pc %h v %b ins %h exp 1 fc 0 %h", i, halted, pc, ifid_valid, ifid_ins, NOP); end
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset got pc %h h %b exp 0 0", pc, halted); end
    @(posedge clk); #1 rstn = 1'b1;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall    = ($urandom_range(99) < 25);
      redirect = ($urandom_range(99) < 15);
      halt     = ($urandom_range(99) < 2);
      target   = $urandom;
      if ($urandom_range(99) == 0) begin
        #2 rstn = 1'b0;
        model_reset();
        @(posedge clk); #1 rstn = 1'b1;
      end
      cycle();
      checks++;
      if (pc !== m_pc || im_addr !== m_pc[11:2] || halted !== m_halt)
        begin errors++; $display("FAIL rand_pc_%0d got pc %h a %h h %b exp %h %h %b", n, pc, im_addr, halted, m_pc, m_pc[11:2], m_halt); end
      checks++;
      if (ifid_pc !== m_ipc || ifid_pc4 !== m_ipc4 || ifid_ins !== m_ins || ifid_valid !== m_valid)
        begin errors++; $display("FAIL rand_ifid_%0d got %h %h %h %b exp %h %h %h %b", n, ifid_pc, ifid_pc4, ifid_ins, ifid_valid, m_ipc, m_ipc4, m_ins, m_valid); end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    checks++; if (pc_w !== 32'hFFFF_FFF8 || ifid_pc4_w !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_reset got pc %h pc4 %h exp fffffff8 fffffffc", pc_w, ifid_pc4_w); end
    rstn_w = 1'b1;
    cycle();
    checks++; if (pc_w !== 32'hFFFF_FFF8 || im_addr_w !== 4'd14 || ifid_valid_w !== 1'b0)
      begin errors++; $display("FAIL wrap_boot got pc %h a %h v %b exp fffffff8 e 0", pc_w, im_addr_w, ifid_valid_w); end
    cycle();
    checks++; if (ifid_pc_w !== 32'hFFFF_FFF8 || ifid_pc4_w !== 32'hFFFF_FFFC || ifid_ins_w !== rom_w[14] || ifid_valid_w !== 1'b1)
      begin errors++; $display("FAIL wrap_f0 got %h %h %h %b exp fffffff8 fffffffc %h 1", ifid_pc_w, ifid_pc4_w, ifid_ins_w, ifid_valid_w, rom_w[14]); end
    cycle();
    checks++; if (ifid_pc_w !== 32'hFFFF_FFFC || ifid_pc4_w !== 32'h0 || ifid_ins_w !== rom_w[15] || pc_w !== 32'h0 || im_addr_w !== 4'd0)
      begin errors++; $display("FAIL wrap_f1 got %h %h %h pc %h a %h exp fffffffc 0 %h 0 0", ifid_pc_w, ifid_pc4_w, ifid_ins_w, pc_w, im_addr_w, rom_w[15]); end
    cycle();
    checks++; if (ifid_pc_w !== 32'h0 || ifid_pc4_w !== 32'h4 || ifid_ins_w !== rom_w[0] || halted_w !== 1'b0)
      begin errors++; $display("FAIL wrap_f2 got %h %h %h h %b exp 0 4 %h 0", ifid_pc_w, ifid_pc4_w, ifid_ins_w, halted_w, rom_w[0]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int i = 0; i < 16; i++) rom_w[i] = $urandom;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_halt();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter IM_AWIDTH, default 10: word-address width of instruction memory.
REQ-003 Parameter NOP_INS, default 32'h0000_0000: instruction word inserted for bubbles.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rstn  input  1: reset, asynchronous, active-low.
REQ-006 stall_i  input  1: hazard hold; freeze PC and IF/ID register.
REQ-007 redirect_i  input  1: branch/jump taken, resolved in ID.
REQ-008 target_i  input  32: redirect target byte address.
REQ-009 halt_i  input  1: halt request from ID.
REQ-010 im_addr_o  output  IM_AWIDTH: word address to instruction ROM, equal to pc_o[IM_AWIDTH+1:2].
REQ-011 im_data_i  input  32: combinational ROM read data for im_addr_o.
REQ-012 pc_o  output  32: current fetch PC.
REQ-013 ifid_pc_o  output  32: PC of the instruction held in IF/ID.
REQ-014 ifid_pc4_o  output  32: ifid_pc_o + 4.
REQ-015 ifid_ins_o  output  32: instruction held in IF/ID.
REQ-016 ifid_valid_o  output  1: IF/ID holds a real instruction.
REQ-017 halted_o  output  1: fetch unit in HALT state.

Function
REQ-018 FSM states BOOT, RUN, HALT, encoded in a 2-bit register.
- BOOT: one cycle after reset release; PC=RESET_PC, IF/ID bubble; next state RUN unconditionally.
- RUN: normal fetch.
- HALT: exited only by reset.
REQ-019 RUN, no stall, no redirect, no halt: pc <= pc+4; IF/ID <= {pc, pc+4, im_data_i, valid=1}; latency fetch-to-IF/ID is one cycle.
REQ-020 Priority in RUN: stall_i > halt_i > redirect_i > sequential.
REQ-021 stall_i=1: pc and all IF/ID registers hold their values, including valid; redirect_i and halt_i are ignored that cycle, and ID re-asserts them once the stall clears.
REQ-022 redirect_i=1 (no stall): pc <= {target_i[31:2],2'b00}; IF/ID <= bubble (ins=NOP_INS, valid=0, pc fields hold); no branch delay slot.
REQ-023 halt_i=1 (no stall): next state HALT; pc holds; IF/ID <= bubble.
REQ-024 In HALT and BOOT: pc holds, ifid_valid_o=0, ifid_ins_o=NOP_INS, halted_o=1 only in HALT.
REQ-025 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; ifid_pc4_o wraps identically.
REQ-026 im_addr_o truncates the PC to IM_AWIDTH bits; addresses beyond ROM depth alias modulo 2^IM_AWIDTH words.
REQ-027 All outputs are registered or derived combinationally only from registered pc; none depends on stall_i, redirect_i or halt_i combinationally.

Reset
REQ-028 rstn=0 asynchronously forces: state=BOOT, pc=RESET_PC, ifid_pc=RESET_PC, ifid_pc4=RESET_PC+4, ifid_ins=NOP_INS, ifid_valid=0, halted_o=0.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT overrides everything; the first valid IF/ID after release is RESET_PC's instruction, two rising edges after rstn rises.

Structure
REQ-030 Shared package cpu_pkg holds the FSM state typedef (BOOT/RUN/HALT), NOP encoding and the default reset vector; id_stage and the hazard unit import the same package.
REQ-031 One sub-module, ifid_reg, implements the IF/ID register with hold (stall) and bubble (flush) controls; next-PC select and FSM stay in if_stage.

Verification
REQ-032 Reset then 4 free-running cycles, ROM[0..3]=A0..A3 -> after BOOT, IF/ID shows pc 0,4,8 with ins A0,A1,A2, valid=1 each cycle.
REQ-033 stall_i=1 for 3 cycles while IF/ID holds pc=8 -> pc_o stays 12, IF/ID stays {8,A2,valid=1}; resumes at pc 12 on release.
REQ-034 redirect_i=1, target_i=32'h0000_0043 at pc_o=16 -> next pc_o=32'h40, IF/ID bubble (valid=0, ins=NOP), next cycle IF/ID pc=32'h40.
REQ-035 stall_i=1 and redirect_i=1 same cycle -> no PC change, IF/ID held; redirect taken next cycle when stall_i=0 and redirect_i=1.
REQ-036 halt_i=1 at pc_o=32'hFC -> halted_o=1 next cycle, pc_o frozen at 32'hFC, ifid_valid_o=0 for 10 cycles; rstn pulse returns pc_o to RESET_PC, halted_o=0.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> fetched PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; ifid_pc4_o 0000_0000 for pc FFFF_FFFC.
